mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 21 ++
 rtl/mem_store_align.sv | 53 +++++
 rtl/mem_access_unit.sv | 131 +++++++++++++
 tb/tb_mem_access_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the load/store bus access unit: FSM encoding,
// RV32I load/store funct3 codes and the default bus timeout.
package mem_access_unit_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  localparam logic [7:0] TIMEOUT_DEFAULT = 8'd255;

endpackage

// File: rtl/mem_store_align.sv
// Combinational legality/alignment check plus byte-enable and lane
// replication for one load/store request.
module mem_store_align
  import mem_access_unit_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  fu3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic        misalign
);

  always_comb begin
    be         = 4'b0000;
    lane_wdata = wdata;
    misalign   = 1'b0;
    if (is_store) begin
      case (fu3)
        F3_SB: begin
          be         = 4'b0001 << addr_lo;
          lane_wdata = {4{wdata[7:0]}};
        end
        F3_SH: begin
          be         = 4'b0011 << {addr_lo[1], 1'b0};
          lane_wdata = {2{wdata[15:0]}};
          misalign   = addr_lo[0];
        end
        F3_SW: begin
          be       = 4'b1111;
          misalign = |addr_lo;
        end
        default: misalign = 1'b1;
      endcase
    end else begin
      // Loads always fetch the full word; the load unit picks the lane.
      case (fu3)
        F3_LB, F3_LBU: be = 4'b1111;
        F3_LH, F3_LHU: begin
          be       = 4'b1111;
          misalign = addr_lo[0];
        end
        F3_LW: begin
          be       = 4'b1111;
          misalign = |addr_lo;
        end
        default: misalign = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding bus access sequencer: accepts one load/store from the
// control FSM, drives the memory bus until mem_ready or timeout, pulses done.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  fu3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata_word,
  output logic [1:0]  addr_lo,
  output logic        misalign,
  output logic        bus_err,
  output logic [1:0]  fsm_state
);

  // Bus handshake: a transfer completes on the rising edge where mem_req and
  // mem_ready are both 1; request fields stay frozen while mem_req is high.

  logic [1:0]  state;
  logic [7:0]  timer;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic        misalign_next;
  logic        timeout_hit;

  mem_store_align u_align (
    .is_store   (is_store),
    .fu3        (fu3),
    .addr_lo    (addr[1:0]),
    .wdata      (wdata),
    .be         (be_next),
    .lane_wdata (wdata_next),
    .misalign   (misalign_next)
  );

  assign timeout_hit = (timer == (TIMEOUT - 8'd1));
  assign busy        = (state != ST_IDLE);
  assign fsm_state   = state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      timer      <= 8'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_be     <= 4'd0;
      mem_wdata  <= 32'd0;
      done       <= 1'b0;
      rdata_word <= 32'd0;
      addr_lo    <= 2'd0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done     <= 1'b0;
          misalign <= 1'b0;
          bus_err  <= 1'b0;
          if (start) begin
            addr_lo <= addr[1:0];
            if (misalign_next) begin
              // Illegal requests never reach the bus.
              state    <= ST_DONE;
              done     <= 1'b1;
              misalign <= 1'b1;
            end else begin
              state     <= ST_ACCESS;
              timer     <= 8'd0;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
            end
          end
        end

        ST_ACCESS: begin
          if (mem_ready) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) begin
              rdata_word <= mem_rdata;
            end
          end else if (timeout_hit) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            bus_err <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else begin
            timer <= timer + 8'd1;
          end
        end

        ST_DONE: begin
          state    <= ST_IDLE;
          done     <= 1'b0;
          misalign <= 1'b0;
          bus_err  <= 1'b0;
        end

        default: begin
          state   <= ST_IDLE;
          done    <= 1'b0;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses push expected bus
// requests and completions; a negedge monitor pops and compares them.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  fu3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        busy, done, misalign, bus_err;
  logic [31:0] rdata_word;
  logic [1:0]  addr_lo, fsm_state;

  mem_access_unit #(.TIMEOUT(8'd4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .is_store   (is_store),
    .fu3        (fu3),
    .addr       (addr),
    .wdata      (wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .rdata_word (rdata_word),
    .addr_lo    (addr_lo),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .fsm_state  (fsm_state)
  );

  // Clock/reset
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    int          len;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  lo;
    logic        mis;
    logic        berr;
    int          lat;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  int checks = 0;
  int errors = 0;
  int start_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Bus responder: mem_ready on the ready_at-th request cycle (0 = never).
  int          ready_at = 0;
  logic [31:0] rdata_val = 32'd0;
  int          req_cnt = 0;
  always @(posedge clock) begin
    #1;
    if (mem_req) begin
      req_cnt++;
      mem_ready = (ready_at != 0) && (req_cnt == ready_at);
    end else begin
      req_cnt   = 0;
      mem_ready = 1'b0;
    end
    mem_rdata = mem_ready ? rdata_val : 32'hBAD0_BAD0;
  end

  // Monitor
  logic     prev_req = 1'b0;
  bus_exp_t cur_bus;
  int       req_len = 0;
  logic     stable = 1'b1;
  always @(negedge clock) begin
    if (reset && mem_req && !prev_req) begin
      chk("req_expected", (bus_q.size() != 0), 1);
      if (bus_q.size() != 0) begin
        cur_bus = bus_q.pop_front();
        chk("mem_addr", mem_addr, cur_bus.addr);
        chk("mem_be", {28'd0, mem_be}, {28'd0, cur_bus.be});
        chk("mem_we", {31'd0, mem_we}, {31'd0, cur_bus.we});
        if (cur_bus.we) chk("mem_wdata", mem_wdata, cur_bus.wdata);
      end
      req_len = 1;
      stable  = 1'b1;
    end else if (mem_req && prev_req) begin
      req_len++;
      if (mem_addr !== cur_bus.addr || mem_be !== cur_bus.be || mem_we !== cur_bus.we)
        stable = 1'b0;
    end else if (!mem_req && prev_req) begin
      chk("req_len", req_len, cur_bus.len);
      chk("req_stable", {31'd0, stable}, 1);
    end
    if (done) begin
      chk("done_expected", (done_q.size() != 0), 1);
      if (done_q.size() != 0) begin
        done_exp_t d;
        d = done_q.pop_front();
        chk("rdata_word", rdata_word, d.rdata);
        chk("addr_lo", {30'd0, addr_lo}, {30'd0, d.lo});
        chk("misalign", {31'd0, misalign}, {31'd0, d.mis});
        chk("bus_err", {31'd0, bus_err}, {31'd0, d.berr});
        chk("latency", cyc - start_cyc, d.lat);
        chk("req_low_at_done", {31'd0, mem_req}, 0);
      end
    end
    prev_req = mem_req;
  end

  // Drivers
  task automatic do_access(
    input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
    input int rdy_at, input logic [31:0] rd, input logic legal,
    input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wdata, input int e_len,
    input logic [31:0] e_rdata, input logic [1:0] e_lo, input logic e_mis, input logic e_berr,
    input int e_lat, input logic poke_busy, input logic poke_done);
    bus_exp_t  b;
    done_exp_t d;
    logic      got;
    b = '{e_addr, e_be, e_wdata, st, e_len};
    d = '{e_rdata, e_lo, e_mis, e_berr, e_lat};
    if (legal) bus_q.push_back(b);
    done_q.push_back(d);
    ready_at  = rdy_at;
    rdata_val = rd;
    @(posedge clock); #1;
    start = 1'b1; is_store = st; fu3 = f3; addr = a; wdata = wd;
    start_cyc = cyc;
    @(posedge clock); #1;
    start = 1'b0;
    if (poke_busy) begin
      start = 1'b1; is_store = 1'b0; fu3 = 3'd2; addr = 32'h0000_0F00;
      @(posedge clock); #1;
      start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", {31'd0, got}, 1);
    if (poke_done) begin
      start = 1'b1; is_store = 1'b0; fu3 = 3'd2; addr = 32'h0000_0E00;
    end
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {20'd0, mem_req, mem_we, busy, done, misalign, bus_err, addr_lo, mem_be, fsm_state}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_rdata_word"}, rdata_word, 0);
  endtask

  task automatic reset_mid_access();
    bus_exp_t b;
    b = '{32'h0000_0500, 4'b1111, 32'd0, 1'b0, 2};
    bus_q.push_back(b);
    ready_at = 0;
    @(posedge clock); #1;
    start = 1'b1; is_store = 1'b0; fu3 = 3'd2; addr = 32'h0000_0500;
    start_cyc = cyc;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check_reset_outputs("rst_mid");
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("rst_init");
    reset = 1'b1;
    @(posedge clock); #1;

    //         st    f3    addr          wdata         rdy rdata         legal e_addr        e_be     e_wdata       len e_rdata       lo    mis   berr  lat pb    pd
    do_access(1'b0, 3'd2, 32'h0000_0100, 32'h0,        1, 32'hDEAD_BEEF, 1'b1, 32'h0000_0100, 4'b1111, 32'h0,        1, 32'hDEAD_BEEF, 2'd0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    do_access(1'b1, 3'd0, 32'h0000_0203, 32'h0000_00A5, 1, 32'h0,       1'b1, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 1, 32'hDEAD_BEEF, 2'd3, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    do_access(1'b1, 3'd1, 32'h0000_0102, 32'h1234_BEEF, 4, 32'h0,       1'b1, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 4, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b0, 5, 1'b1, 1'b0);
    do_access(1'b0, 3'd2, 32'h0000_0101, 32'h0,        1, 32'h0,        1'b0, 32'h0,         4'b0000, 32'h0,        0, 32'hDEAD_BEEF, 2'd1, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    do_access(1'b0, 3'd2, 32'h0000_0300, 32'h0,        0, 32'h0,        1'b1, 32'h0000_0300, 4'b1111, 32'h0,        4, 32'hDEAD_BEEF, 2'd0, 1'b0, 1'b1, 5, 1'b0, 1'b1);
    do_access(1'b0, 3'd2, 32'h0000_0304, 32'h0,        4, 32'hCAFE_F00D, 1'b1, 32'h0000_0304, 4'b1111, 32'h0,       4, 32'hCAFE_F00D, 2'd0, 1'b0, 1'b0, 5, 1'b0, 1'b0);
    do_access(1'b1, 3'd2, 32'h0000_0408, 32'h1234_5678, 1, 32'h0,       1'b1, 32'h0000_0408, 4'b1111, 32'h1234_5678, 1, 32'hCAFE_F00D, 2'd0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    do_access(1'b1, 3'd1, 32'h0000_0101, 32'h0000_FFFF, 1, 32'h0,       1'b0, 32'h0,         4'b0000, 32'h0,        0, 32'hCAFE_F00D, 2'd1, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    do_access(1'b0, 3'd3, 32'h0000_0000, 32'h0,        1, 32'h0,        1'b0, 32'h0,         4'b0000, 32'h0,        0, 32'hCAFE_F00D, 2'd0, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    do_access(1'b1, 3'd4, 32'h0000_0000, 32'h0,        1, 32'h0,        1'b0, 32'h0,         4'b0000, 32'h0,        0, 32'hCAFE_F00D, 2'd0, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    do_access(1'b0, 3'd4, 32'h0000_0107, 32'h0,        1, 32'h1122_3344, 1'b1, 32'h0000_0104, 4'b1111, 32'h0,       1, 32'h1122_3344, 2'd3, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    do_access(1'b1, 3'd0, 32'h0000_0200, 32'h0000_00C3, 1, 32'h0,       1'b1, 32'h0000_0200, 4'b0001, 32'hC3C3_C3C3, 1, 32'h1122_3344, 2'd0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    do_access(1'b1, 3'd1, 32'h0000_0100, 32'hAAAA_5555, 2, 32'h0,       1'b1, 32'h0000_0100, 4'b0011, 32'h5555_5555, 2, 32'h1122_3344, 2'd0, 1'b0, 1'b0, 3, 1'b0, 1'b0);

    reset_mid_access();

    do_access(1'b0, 3'd2, 32'h0000_0010, 32'h0,        1, 32'h0BAD_F00D, 1'b1, 32'h0000_0010, 4'b1111, 32'h0,       1, 32'h0BAD_F00D, 2'd0, 1'b0, 1'b0, 2, 1'b0, 1'b0);

    repeat (4) @(posedge clock);
    #1;
    chk("bus_q_drained", bus_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    chk("idle_at_end", {31'd0, busy}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
